fraction_reducer: RTL and testbench
===================================

Name: fraction_reducer

Overview:
- Downstream consumer of the gcd stage.
- Takes an operand pair (a, b) together with the gcd value the gcd stage computed for it, and returns the reduced fraction a/g, b/g.
- Uses two iterative restoring dividers that share one divisor, with a valid/ready handshake on both sides.
- Flags inconsistent inputs (g = 0, or g does not divide both operands) and coprime pairs.

Parameters:
- WIDTH, 8, bit width of operands, gcd and quotients.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  upstream presents num_in/den_in/gcd_in.
- in_ready  output  1  block can accept a new triple.
- num_in  input  WIDTH  first operand (a).
- den_in  input  WIDTH  second operand (b).
- gcd_in  input  WIDTH  gcd(a, b) from the gcd stage.
- out_valid  output  1  result registers valid.
- out_ready  input  1  downstream accepts the result.
- num_out  output  WIDTH  a / g quotient.
- den_out  output  WIDTH  b / g quotient.
- div_err  output  1  g = 0, or a nonzero remainder occurred.
- coprime  output  1  g = 1.
- busy  output  1  high in DIV state.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, all datapath registers cleared.
  - in_ready = 0 while reset is low, 1 after release.
  - out_valid = 0, num_out = 0, den_out = 0, div_err = 0, coprime = 0, busy = 0.
- States are IDLE, DIV, DONE. in_ready = (state == IDLE). busy = (state == DIV). out_valid = (state == DONE).
- Accept: at a rising edge with state == IDLE and in_valid = 1, latch num_in, den_in and gcd_in.
  - gcd_in == 0: go to DONE. num_out = num_in, den_out = den_in, div_err = 1, coprime = 0. Latency is 1 edge.
  - gcd_in == 1: go to DONE. num_out = num_in, den_out = den_in, div_err = 0, coprime = 1. Latency is 1 edge.
  - Otherwise: go to DIV. Clear the partial remainders (WIDTH+1 bits each), load the quotient shift registers with the operands, and set the iteration counter to 0.
- DIV: one restoring step per edge for both dividers in parallel, MSB first.
  - r = {r[WIDTH-1:0], q[WIDTH-1]}, q <<= 1.
  - If r >= g: r -= g and q[0] = 1.
- After WIDTH steps (the counter reaches WIDTH-1 on the last step), go to DONE.
  - num_out and den_out take the quotients.
  - div_err = (rem_a != 0) | (rem_b != 0).
  - coprime = 0.
  - out_valid is first high WIDTH+1 edges after the acceptance edge (9 for WIDTH = 8).
- DONE:
  - Outputs and flags are held stable while out_ready = 0; backpressure is unbounded.
  - On an edge with out_ready = 1, go to IDLE and drop out_valid.
  - in_ready rises that same edge. A new triple cannot be accepted in the same cycle as the output handshake; the minimum issue interval is 2 cycles (fast path) or WIDTH+2 cycles (divide path).
- in_valid while not in IDLE is ignored. The input is not latched, and upstream must hold it until in_ready.
- Input changes after acceptance have no effect on the operation in flight.
- Arithmetic:
  - Unsigned throughout.
  - A quotient never exceeds its dividend, so no overflow is possible.
  - num_in = 0 with g > 1 gives num_out = 0 and no error.
- Reset asserted mid-DIV or mid-DONE aborts immediately: the partial result is discarded and the block returns to reset values.
- Reset release with in_valid already high: the first accept happens at the first rising edge after release.

Test Plan:
- a=200, b=68, g=4 -> num_out=50, den_out=17, div_err=0, coprime=0; out_valid 9 edges after acceptance.
- a=120, b=40, g=40 -> 3, 1, div_err=0. Then a=20, b=43, g=1 -> 20, 43, coprime=1, out_valid 1 edge after acceptance.
- a=0, b=0, g=0 -> num_out=0, den_out=0, div_err=1, latency 1. Then a=100, b=72, g=8 (wrong) -> 12, 9, div_err=1 (remainder 4).
- Backpressure: a=153, b=18, g=9 with out_ready low for 5 cycles after out_valid -> 17, 2 held constant, in_ready=0 throughout. Raise out_ready -> one handshake, then in_ready=1.
- Reset pulse (reset=0 for half a cycle) 3 edges into DIV for a=225, b=20, g=5 -> all outputs 0 immediately. Reissue -> 45, 4 correct.
- Back-to-back stream of the 15 pairs from the gcd stage with out_ready tied 1 -> every result matches a/g, b/g with div_err=0. Gap between accepts is exactly WIDTH+2 cycles on the divide path.

Source files
------------

// File: rtl/fraction_reducer.sv
// Reduces a/b by their gcd using two parallel restoring dividers that share one divisor.
// Fast path for g = 0 (error) and g = 1 (coprime); valid/ready handshake on both sides.
module fraction_reducer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num_in,
  input  logic [WIDTH-1:0] den_in,
  input  logic [WIDTH-1:0] gcd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] num_out,
  output logic [WIDTH-1:0] den_out,
  output logic             div_err,
  output logic             coprime,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] g_q, qa_q, qb_q;
  logic [WIDTH:0]   ra_q, rb_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH-1:0] qa_d, qb_d;
  logic [WIDTH:0]   ra_d, rb_d;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   r,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] g);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] qn;
    logic             fits;
    sh    = {r[WIDTH-1:0], q[WIDTH-1]};
    fits  = (sh >= {1'b0, g});
    qn    = q << 1;
    qn[0] = fits;
    if (fits) sh = sh - {1'b0, g};
    return {sh, qn};
  endfunction

  always_comb begin
    {ra_d, qa_d} = div_step(ra_q, qa_q, g_q);
    {rb_d, qb_d} = div_step(rb_q, qb_q, g_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      g_q     <= '0;
      qa_q    <= '0;
      qb_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      cnt_q   <= '0;
      num_out <= '0;
      den_out <= '0;
      div_err <= 1'b0;
      coprime <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            g_q <= gcd_in;
            if (gcd_in == '0) begin
              num_out <= num_in;
              den_out <= den_in;
              div_err <= 1'b1;
              coprime <= 1'b0;
              state_q <= StDone;
            end else if (gcd_in == WIDTH'(1)) begin
              num_out <= num_in;
              den_out <= den_in;
              div_err <= 1'b0;
              coprime <= 1'b1;
              state_q <= StDone;
            end else begin
              qa_q    <= num_in;
              qb_q    <= den_in;
              ra_q    <= '0;
              rb_q    <= '0;
              cnt_q   <= '0;
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          qa_q  <= qa_d;
          qb_q  <= qb_d;
          ra_q  <= ra_d;
          rb_q  <= rb_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            num_out <= qa_d;
            den_out <= qb_d;
            div_err <= (ra_d != '0) || (rb_d != '0);
            coprime <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gate with reset so upstream never sees ready while the block is held in reset.
  assign in_ready  = reset && (state_q == StIdle);
  assign busy      = (state_q == StDiv);
  assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_fraction_reducer.sv
// Directed self-checking bench for fraction_reducer: fast paths, divide path, errors,
// backpressure, mid-operation reset and a back-to-back stream.
module tb_fraction_reducer;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] num_in = '0, den_in = '0, gcd_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] num_out, den_out;
  logic             div_err, coprime, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  fraction_reducer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .num_in(num_in), .den_in(den_in), .gcd_in(gcd_in), .out_valid(out_valid),
    .out_ready(out_ready), .num_out(num_out), .den_out(den_out), .div_err(div_err),
    .coprime(coprime), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Issue one triple and check the result; latency counts edges from the accept edge inclusive.
  task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                        input int unsigned g, input int unsigned en, input int unsigned ed,
                        input int unsigned eerr, input int unsigned ecop,
                        input int unsigned elat);
    int edges;
    wait_ready(tag);
    num_in   = WIDTH'(a);
    den_in   = WIDTH'(b);
    gcd_in   = WIDTH'(g);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    num_in   = 8'hff;
    den_in   = 8'hff;
    gcd_in   = 8'h03;
    edges    = 1;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_lat"}, edges, elat);
    check({tag, "_num"}, num_out, en);
    check({tag, "_den"}, den_out, ed);
    check({tag, "_err"}, div_err, eerr);
    check({tag, "_cop"}, coprime, ecop);
    if (out_ready) begin
      tick();
      check({tag, "_hs_ready"}, {in_ready, out_valid}, 2'b10);
    end
  endtask

  int unsigned pa[15] = '{12, 100, 255, 48, 9, 64, 210, 0, 121, 250, 36, 84, 128, 240, 91};
  int unsigned pb[15] = '{18, 75, 85, 180, 6, 48, 14, 7, 77, 100, 24, 126, 96, 30, 65};

  initial begin
    // Reset state
    #12;
    check("rst_outs", {in_ready, out_valid, busy, div_err, coprime}, 5'b0);
    check("rst_data", {num_out, den_out}, 16'h0);
    reset = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1);
    @(negedge clk);

    run_op("t200_68", 200, 68, 4, 50, 17, 0, 0, 9);
    run_op("t120_40", 120, 40, 40, 3, 1, 0, 0, 9);
    run_op("t20_43", 20, 43, 1, 20, 43, 0, 1, 1);
    run_op("t0_0", 0, 0, 0, 0, 0, 1, 0, 1);
    run_op("t100_72", 100, 72, 8, 12, 9, 1, 0, 9);

    // Backpressure
    out_ready = 1'b0;
    run_op("bp", 153, 18, 9, 17, 2, 0, 0, 9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {out_valid, in_ready, num_out, den_out, div_err},
            {1'b1, 1'b0, 8'd17, 8'd2, 1'b0});
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", {in_ready, out_valid}, 2'b10);

    // Reset pulse mid-divide
    wait_ready("rp");
    num_in = 8'd225; den_in = 8'd20; gcd_in = 8'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rp_outs", {in_ready, out_valid, busy, div_err, coprime}, 5'b0);
    check("rp_data", {num_out, den_out}, 16'h0);
    #4 reset = 1'b1;
    #1;
    check("rp_ready", {in_ready, busy}, 2'b10);
    run_op("rp_reissue", 225, 20, 5, 45, 4, 0, 0, 9);

    // Back-to-back stream, in_valid held high throughout
    begin
      int last_acc;
      int g;
      int n;
      last_acc = 0;
      for (int i = 0; i < 15; i++) begin
        g = gcd(pa[i], pb[i]);
        num_in = WIDTH'(pa[i]); den_in = WIDTH'(pb[i]); gcd_in = WIDTH'(g);
        in_valid = 1'b1;
        wait_ready("st");
        tick();
        if (i > 0) check("st_gap", cyc - last_acc, WIDTH + 2);
        last_acc = cyc;
        num_in = 8'h55; den_in = 8'haa; gcd_in = 8'h07;
        n = 0;
        while (!out_valid && n < 40) begin
          tick();
          n++;
        end
        check("st_num", num_out, pa[i] / g);
        check("st_den", den_out, pb[i] / g);
        check("st_err", div_err, 0);
        tick();
      end
      in_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
